// File: rtl/softmax_row_feeder.sv
// softmax_row_feeder
//   Front end of the softmax datapath. Collects one row of N-lane beats
//   (16-bit signed lanes, lane i = bits [16*i+15:16*i]) into a small buffer
//   while tracking the row maximum, then replays the row one beat per cycle
//   with the row max broadcast to every lane.
// Ports
//   clk          : clock, all logic on rising edge
//   rst          : synchronous reset, active-low
//   s_tvalid     : input beat valid
//   s_tready     : feeder can accept a beat (low only while replaying)
//   s_tdata      : input beat, N signed 16-bit lanes
//   s_tlast      : input beat is last of row
//   vect_x_out   : replayed row beat
//   vect_max_out : row max replicated across N lanes
//   out_tvalid   : replay outputs valid this cycle
//   out_tlast    : with out_tvalid, final beat of row
//   ovf_err      : sticky, a row ran past DEPTH beats
module softmax_row_feeder #(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_tvalid,
    output logic            s_tready,
    input  logic [N*16-1:0] s_tdata,
    input  logic            s_tlast,
    output logic [N*16-1:0] vect_x_out,
    output logic [N*16-1:0] vect_max_out,
    output logic            out_tvalid,
    output logic            out_tlast,
    output logic            ovf_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_EMIT
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [N*16-1:0]       r_buf [DEPTH];
    logic [CW-1:0]         r_wr_cnt;
    logic [CW-1:0]         r_rd_cnt;
    logic signed [15:0]    r_row_max;

    logic signed [15:0]    w_beat_max;
    logic                  w_accept;
    logic                  w_full;
    logic                  w_last_rd;

    // Signed max across the lanes of the beat currently on s_tdata.
    always_comb begin
        w_beat_max = s_tdata[15:0];
        for (int unsigned i = 1; i < N; i++) begin
            if ($signed(s_tdata[16*i +: 16]) > w_beat_max)
                w_beat_max = s_tdata[16*i +: 16];
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        s_tready     = (r_state != ST_EMIT);
        w_accept     = s_tvalid && s_tready;
        w_full       = (r_state == ST_COLLECT) && (r_wr_cnt == CW'(DEPTH - 1));
        w_last_rd    = (r_rd_cnt == (r_wr_cnt - CW'(1)));
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept)
                    w_next_state = s_tlast ? ST_EMIT : ST_COLLECT;
            end
            ST_COLLECT: begin
                if (w_accept && (s_tlast || w_full))
                    w_next_state = ST_EMIT;
            end
            ST_EMIT: begin
                if (w_last_rd)
                    w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    // Row storage carries no reset; only entries below wr_cnt are ever read.
    always_ff @(posedge clk) begin
        if (w_accept)
            r_buf[r_wr_cnt[AW-1:0]] <= s_tdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_cnt     <= '0;
            r_rd_cnt     <= '0;
            r_row_max    <= 16'sh8000;
            vect_x_out   <= '0;
            vect_max_out <= '0;
            out_tvalid   <= 1'b0;
            out_tlast    <= 1'b0;
            ovf_err      <= 1'b0;
        end else begin
            out_tvalid <= 1'b0;
            out_tlast  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_wr_cnt  <= CW'(1);
                        r_row_max <= w_beat_max;
                    end
                end
                ST_COLLECT: begin
                    if (w_accept) begin
                        r_wr_cnt <= r_wr_cnt + CW'(1);
                        // Strict compare: ties keep the existing max.
                        if (w_beat_max > r_row_max)
                            r_row_max <= w_beat_max;
                        // Buffer full without tlast: close the row here.
                        if (w_full && !s_tlast)
                            ovf_err <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    out_tvalid   <= 1'b1;
                    out_tlast    <= w_last_rd;
                    vect_x_out   <= r_buf[r_rd_cnt[AW-1:0]];
                    vect_max_out <= {N{r_row_max}};
                    if (w_last_rd) begin
                        r_wr_cnt  <= '0;
                        r_rd_cnt  <= '0;
                        r_row_max <= 16'sh8000;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_row_feeder.sv
// tb_softmax_row_feeder
//   Scoreboard bench for softmax_row_feeder. The driver offers beats and, on
//   acceptance, feeds a row-level model that queues the expected replay beats
//   (data, max, tlast and the edge each must appear on). A monitor compares
//   the DUT outputs, s_tready and ovf_err against the model every cycle.
module tb_softmax_row_feeder;

    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int W     = N * 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic [W-1:0] s_tdata = '0;
    logic         s_tlast = 1'b0;
    logic [W-1:0] vect_x_out;
    logic [W-1:0] vect_max_out;
    logic         out_tvalid;
    logic         out_tlast;
    logic         ovf_err;

    softmax_row_feeder #(.N(N), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .s_tdata      (s_tdata),
        .s_tlast      (s_tlast),
        .vect_x_out   (vect_x_out),
        .vect_max_out (vect_max_out),
        .out_tvalid   (out_tvalid),
        .out_tlast    (out_tlast),
        .ovf_err      (ovf_err)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        logic [W-1:0] x;
        logic [15:0]  m;
        logic         l;
        int           e;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] cur_row[$];
    bit           ovf_exp    = 1'b0;
    int           busy_until = 0;
    int           checks     = 0;
    int           failures   = 0;
    bit           mon_en     = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic logic [15:0] row_max_of();
        int           m;
        int           v;
        logic [W-1:0] t;
        m = -32768;
        for (int b = 0; b < cur_row.size(); b++) begin
            t = cur_row[b];
            for (int l = 0; l < N; l++) begin
                v = $signed(t[16*l +: 16]);
                if (v > m) m = v;
            end
        end
        return m[15:0];
    endfunction

    // A row closes on tlast or when it reaches DEPTH beats; its beats then
    // appear on consecutive edges starting the edge after the closing beat.
    task automatic model_accept(input logic [W-1:0] d, input logic last, input int k);
        logic [15:0] m;
        exp_t        e;
        cur_row.push_back(d);
        if (last || cur_row.size() == DEPTH) begin
            if (!last) ovf_exp = 1'b1;
            m = row_max_of();
            for (int j = 0; j < cur_row.size(); j++) begin
                e.x = cur_row[j];
                e.m = m;
                e.l = (j == cur_row.size() - 1);
                e.e = k + 1 + j;
                exp_q.push_back(e);
            end
            busy_until = k + cur_row.size();
            cur_row.delete();
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("s_tready", {{(W-1){1'b0}}, s_tready}, {{(W-1){1'b0}}, (edge_n >= busy_until)});
            chk("ovf_err", {{(W-1){1'b0}}, ovf_err}, {{(W-1){1'b0}}, ovf_exp});
            if (out_tvalid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%0h expected=none (edge %0d)", vect_x_out, edge_n);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_edge", W'(edge_n), W'(e.e));
                    chk("vect_x", vect_x_out, e.x);
                    chk("vect_max", vect_max_out, {N{e.m}});
                    chk("out_tlast", {{(W-1){1'b0}}, out_tlast}, {{(W-1){1'b0}}, e.l});
                end
            end else begin
                chk("idle_tlast", {{(W-1){1'b0}}, out_tlast}, '0);
                if (exp_q.size() > 0 && exp_q[0].e <= edge_n) begin
                    e = exp_q.pop_front();
                    checks++;
                    failures++;
                    $display("FAIL missing_beat actual=no_valid expected=%0h (edge %0d)", e.x, edge_n);
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            s_tdata  = {4{$urandom()}};
        end
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic last);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc) begin
            @(negedge clk);
            s_tvalid = 1'b1;
            s_tdata  = d;
            s_tlast  = last;
            acc      = s_tready;
            @(posedge clk);
            #1;
            if (acc) model_accept(d, last, edge_n);
            tries++;
            if (!acc && tries > 40) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout actual=not_ready expected=ready (edge %0d)", edge_n);
                break;
            end
        end
    endtask

    task automatic do_reset(input int pre);
        idle(pre);
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        cur_row.delete();
        ovf_exp    = 1'b0;
        busy_until = 0;
        @(negedge clk);
        chk("rst_tvalid", {{(W-1){1'b0}}, out_tvalid}, '0);
        chk("rst_tlast", {{(W-1){1'b0}}, out_tlast}, '0);
        chk("rst_x", vect_x_out, '0);
        chk("rst_max", vect_max_out, '0);
        chk("rst_ovf", {{(W-1){1'b0}}, ovf_err}, '0);
        chk("rst_tready", {{(W-1){1'b0}}, s_tready}, {{(W-1){1'b0}}, 1'b1});
        rst = 1'b1;
    endtask

    function automatic logic [W-1:0] rand_beat();
        logic [W-1:0] t;
        for (int l = 0; l < N; l++) begin
            if ($urandom_range(0, 1) == 1)
                t[16*l +: 16] = {1'b1, 15'($urandom())};
            else
                t[16*l +: 16] = 16'($urandom());
        end
        return t;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] b;
        int           len;
        int           t;

        // Power-on reset
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("por_tvalid", {{(W-1){1'b0}}, out_tvalid}, '0);
        chk("por_tlast", {{(W-1){1'b0}}, out_tlast}, '0);
        chk("por_x", vect_x_out, '0);
        chk("por_max", vect_max_out, '0);
        chk("por_ovf", {{(W-1){1'b0}}, ovf_err}, '0);
        rst    = 1'b1;
        mon_en = 1'b1;

        // Single-beat row, lanes 1..8
        for (int l = 0; l < N; l++) b[16*l +: 16] = 16'(l + 1);
        send_beat(b, 1'b1);
        idle(3);

        // Two beats: all 0xFFF0, then lane3 = 0x0100
        b = {N{16'hFFF0}};
        send_beat(b, 1'b0);
        b = '0;
        b[16*3 +: 16] = 16'h0100;
        send_beat(b, 1'b1);
        idle(4);

        // All-negative row; signed compare must pick 0xFFFF
        b = {N{16'h8001}};
        b[16*5 +: 16] = 16'hFFFF;
        send_beat(b, 1'b1);
        idle(3);

        // Five beats into a four-deep buffer
        for (int j = 0; j < 5; j++) begin
            b = rand_beat();
            send_beat(b, (j == 4));
        end
        idle(8);

        // Reset mid-collect, then a clean row
        send_beat(rand_beat(), 1'b0);
        send_beat(rand_beat(), 1'b0);
        do_reset(0);
        send_beat(rand_beat(), 1'b0);
        send_beat(rand_beat(), 1'b1);
        idle(4);

        // Reset mid-emit, then a clean row
        for (int j = 0; j < 4; j++) send_beat(rand_beat(), (j == 3));
        do_reset(1);
        b = {N{16'h0011}};
        send_beat(b, 1'b0);
        b = {N{16'hF000}};
        b[16*7 +: 16] = 16'h0022;
        send_beat(b, 1'b1);
        idle(4);

        // Random rows with gaps; gap 0 offers beats while replay is busy
        for (int r = 0; r < 40; r++) begin
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) begin
                send_beat(rand_beat(), (j == len - 1));
                idle($urandom_range(0, 2));
            end
        end

        // Drain
        idle(1);
        t = 0;
        while (exp_q.size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_empty", W'(exp_q.size()), '0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
